// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: per-source synchronizer, level/edge capture and
// IDLE/PENDING/CLAIMED tracking with a saturating count of extra edges.
module plic_gateway #(
  parameter int NUM_SOURCES    = 32,
  parameter int ID_WIDTH       = 6,
  parameter int EDGE_CNT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] irq_sources,
  input  logic [NUM_SOURCES-1:0] edge_mode,
  input  logic                   claim_valid,
  input  logic [ID_WIDTH-1:0]    claim_id,
  input  logic                   complete_valid,
  input  logic [ID_WIDTH-1:0]    complete_id,
  output logic [NUM_SOURCES-1:0] pending,
  output logic [NUM_SOURCES-1:0] in_service,
  output logic                   err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_CLMD = 2'd2;

  // Source 0 is reserved, so its lane is masked off everywhere.
  localparam logic [NUM_SOURCES-1:0] SRC_MASK = {{(NUM_SOURCES-1){1'b1}}, 1'b0};
  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_ZERO = {EDGE_CNT_WIDTH{1'b0}};
  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX  = {EDGE_CNT_WIDTH{1'b1}};
  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_ONE  = EDGE_CNT_WIDTH'(1'b1);

  logic [NUM_SOURCES-1:0]    sync1_r, sync2_r, sync3_r;
  logic [NUM_SOURCES-1:0]    rise_s, edge_s;
  logic [1:0]                state_r     [NUM_SOURCES];
  logic [1:0]                state_nxt_s [NUM_SOURCES];
  logic [EDGE_CNT_WIDTH-1:0] cnt_r       [NUM_SOURCES];
  logic [EDGE_CNT_WIDTH-1:0] cnt_nxt_s   [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]    claim_hit_s, complete_hit_s;
  logic [NUM_SOURCES-1:0]    is_pend_s, is_clmd_s;
  logic [NUM_SOURCES-1:0]    pending_nxt_s, in_service_nxt_s;
  logic                      claim_ok_s, complete_ok_s, err_nxt_s;
  logic [NUM_SOURCES-1:0]    pending_r, in_service_r;
  logic                      err_r;

  assign rise_s     = sync2_r & ~sync3_r;
  assign edge_s     = edge_mode & SRC_MASK;
  assign pending    = pending_r;
  assign in_service = in_service_r;
  assign err        = err_r;

  // Decode claim/complete ids into per-source hits and judge legality.
  always_comb begin
    claim_hit_s    = {NUM_SOURCES{1'b0}};
    complete_hit_s = {NUM_SOURCES{1'b0}};
    is_pend_s      = {NUM_SOURCES{1'b0}};
    is_clmd_s      = {NUM_SOURCES{1'b0}};
    for (int i = 1; i < NUM_SOURCES; i++) begin
      claim_hit_s[i]    = claim_valid && (claim_id == ID_WIDTH'(i));
      complete_hit_s[i] = complete_valid && (complete_id == ID_WIDTH'(i));
      is_pend_s[i]      = (state_r[i] == ST_PEND);
      is_clmd_s[i]      = (state_r[i] == ST_CLMD);
    end
    // Id 0 and out-of-range ids never hit, so they fall out as illegal.
    claim_ok_s    = |(claim_hit_s & is_pend_s);
    complete_ok_s = |(complete_hit_s & is_clmd_s);
    err_nxt_s     = (claim_valid && !claim_ok_s) || (complete_valid && !complete_ok_s);
  end

  // Per-source state machine and edge counter next-state logic.
  always_comb begin
    pending_nxt_s    = {NUM_SOURCES{1'b0}};
    in_service_nxt_s = {NUM_SOURCES{1'b0}};
    state_nxt_s[0]   = ST_IDLE;
    cnt_nxt_s[0]     = CNT_ZERO;
    for (int i = 1; i < NUM_SOURCES; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if ((edge_s[i] && rise_s[i]) || (!edge_s[i] && sync2_r[i])) begin
            state_nxt_s[i] = ST_PEND;
          end else begin
            state_nxt_s[i] = ST_IDLE;
          end
        end
        ST_PEND: begin
          if (claim_hit_s[i]) begin
            state_nxt_s[i] = ST_CLMD;
          end else begin
            state_nxt_s[i] = ST_PEND;
          end
          if (edge_s[i] && rise_s[i] && (cnt_r[i] != CNT_MAX)) begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          end else begin
            cnt_nxt_s[i] = cnt_r[i];
          end
        end
        ST_CLMD: begin
          if (complete_hit_s[i]) begin
            // A rise landing with the complete stands in for the decrement.
            if (edge_s[i] && ((cnt_r[i] != CNT_ZERO) || rise_s[i])) begin
              state_nxt_s[i] = ST_PEND;
              if (rise_s[i]) begin
                cnt_nxt_s[i] = cnt_r[i];
              end else begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
              end
            end else begin
              state_nxt_s[i] = ST_IDLE;
            end
          end else if (edge_s[i] && rise_s[i] && (cnt_r[i] != CNT_MAX)) begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          end else begin
            cnt_nxt_s[i] = cnt_r[i];
          end
        end
        default: begin
          state_nxt_s[i] = ST_IDLE;
          cnt_nxt_s[i]   = CNT_ZERO;
        end
      endcase
      if (!edge_s[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_nxt_s[i];
      end
      pending_nxt_s[i]    = (state_nxt_s[i] == ST_PEND);
      in_service_nxt_s[i] = (state_nxt_s[i] == ST_CLMD);
    end
  end

  // Synchronizer chain, FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r      <= {NUM_SOURCES{1'b0}};
      sync2_r      <= {NUM_SOURCES{1'b0}};
      sync3_r      <= {NUM_SOURCES{1'b0}};
      pending_r    <= {NUM_SOURCES{1'b0}};
      in_service_r <= {NUM_SOURCES{1'b0}};
      err_r        <= 1'b0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= CNT_ZERO;
      end
    end else begin
      sync1_r      <= irq_sources & SRC_MASK;
      sync2_r      <= sync1_r;
      sync3_r      <= sync2_r;
      pending_r    <= pending_nxt_s;
      in_service_r <= in_service_nxt_s;
      err_r        <= err_nxt_s;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: expected outputs are queued per step and
// compared against the DUT one time unit after each rising edge.
module tb_plic_gateway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq, em;
  logic        claim_valid, complete_valid;
  logic [5:0]  claim_id, complete_id;
  logic [31:0] pending, in_service;
  logic        err;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  plic_gateway #(.NUM_SOURCES(32), .ID_WIDTH(6), .EDGE_CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq_sources(irq), .edge_mode(em),
    .claim_valid(claim_valid), .claim_id(claim_id),
    .complete_valid(complete_valid), .complete_id(complete_id),
    .pending(pending), .in_service(in_service), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       obs = pending;
        1:       obs = in_service;
        default: obs = {31'd0, err};
      endcase
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp3(input string tag, input logic [31:0] p, input logic [31:0] s, input logic e);
    exp_q.push_back('{tag: {tag, ".pending"},    sel: 0, val: p});
    exp_q.push_back('{tag: {tag, ".in_service"}, sel: 1, val: s});
    exp_q.push_back('{tag: {tag, ".err"},        sel: 2, val: {31'd0, e}});
    drain();
  endtask

  task automatic do_claim(input logic [5:0] id);
    claim_valid = 1'b1; claim_id = id;
    tick(1);
    claim_valid = 1'b0; claim_id = 6'd0;
  endtask

  task automatic do_complete(input logic [5:0] id);
    complete_valid = 1'b1; complete_id = id;
    tick(1);
    complete_valid = 1'b0; complete_id = 6'd0;
  endtask

  task automatic pulse(input int src);
    irq[src] = 1'b1;
    tick(2);
    irq[src] = 1'b0;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; irq = 32'd0; em = 32'd0;
    claim_valid = 1'b0; claim_id = 6'd0; complete_valid = 1'b0; complete_id = 6'd0;
    tick(2);
    exp3("reset_hold", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick(2);
    exp3("post_reset", 32'h0, 32'h0, 1'b0);

    // Level source 5
    irq[5] = 1'b1;
    tick(2);
    exp3("lvl5_edge2", 32'h0, 32'h0, 1'b0);
    tick(1);
    exp3("lvl5_edge3", 32'h20, 32'h0, 1'b0);
    do_claim(6'd5);
    exp3("lvl5_claim", 32'h0, 32'h20, 1'b0);
    do_complete(6'd5);
    exp3("lvl5_gap", 32'h0, 32'h0, 1'b0);
    tick(1);
    exp3("lvl5_repend", 32'h20, 32'h0, 1'b0);
    irq[5] = 1'b0;
    tick(3);
    exp3("lvl5_sticky", 32'h20, 32'h0, 1'b0);
    do_claim(6'd5);
    do_complete(6'd5);
    tick(1);
    exp3("lvl5_idle", 32'h0, 32'h0, 1'b0);

    // Edge source 3: four pulses, counter reaches 3
    em[3] = 1'b1;
    for (int p = 0; p < 4; p++) pulse(3);
    exp3("edg3_pulses", 32'h08, 32'h0, 1'b0);
    do_claim(6'd3);
    exp3("edg3_claim", 32'h0, 32'h08, 1'b0);
    do_complete(6'd3);
    exp3("edg3_cnt2", 32'h08, 32'h0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      do_claim(6'd3);
      do_complete(6'd3);
      exp3($sformatf("edg3_round%0d", r), (r < 2) ? 32'h08 : 32'h0, 32'h0, 1'b0);
    end

    // Edge source 7: counter saturates at 7
    em[7] = 1'b1;
    pulse(7);
    exp3("edg7_pend", 32'h80, 32'h0, 1'b0);
    do_claim(6'd7);
    for (int p = 0; p < 10; p++) pulse(7);
    exp3("edg7_sat", 32'h0, 32'h80, 1'b0);
    for (int r = 0; r < 7; r++) begin
      do_complete(6'd7);
      exp3($sformatf("edg7_rep%0d", r), 32'h80, 32'h0, 1'b0);
      do_claim(6'd7);
      exp3($sformatf("edg7_clm%0d", r), 32'h0, 32'h80, 1'b0);
    end
    do_complete(6'd7);
    exp3("edg7_idle", 32'h0, 32'h0, 1'b0);

    // Illegal claims/completes with source 2 pending
    irq[2] = 1'b1;
    tick(3);
    exp3("err_setup", 32'h04, 32'h0, 1'b0);
    do_claim(6'd0);
    exp3("err_claim0", 32'h04, 32'h0, 1'b1);
    tick(1);
    exp3("err_claim0_end", 32'h04, 32'h0, 1'b0);
    do_claim(6'd40);
    exp3("err_claim40", 32'h04, 32'h0, 1'b1);
    tick(1);
    exp3("err_claim40_end", 32'h04, 32'h0, 1'b0);
    do_claim(6'd9);
    exp3("err_claim_idle", 32'h04, 32'h0, 1'b1);
    tick(1);
    exp3("err_claim_idle_end", 32'h04, 32'h0, 1'b0);
    do_complete(6'd2);
    exp3("err_cmpl_pend", 32'h04, 32'h0, 1'b1);
    tick(1);
    exp3("err_cmpl_pend_end", 32'h04, 32'h0, 1'b0);

    // Concurrent claim and complete
    irq[4] = 1'b1;
    tick(3);
    exp3("dual_setup", 32'h14, 32'h0, 1'b0);
    do_claim(6'd4);
    exp3("dual_claim4", 32'h04, 32'h10, 1'b0);
    claim_valid = 1'b1; claim_id = 6'd2; complete_valid = 1'b1; complete_id = 6'd4;
    tick(1);
    claim_valid = 1'b0; complete_valid = 1'b0;
    exp3("dual_diff", 32'h0, 32'h04, 1'b0);
    tick(1);
    exp3("dual_diff_after", 32'h10, 32'h04, 1'b0);
    do_complete(6'd2);
    exp3("dual_cmpl2", 32'h10, 32'h0, 1'b0);
    tick(1);
    exp3("dual_repend2", 32'h14, 32'h0, 1'b0);
    claim_valid = 1'b1; claim_id = 6'd2; complete_valid = 1'b1; complete_id = 6'd2;
    tick(1);
    claim_valid = 1'b0; complete_valid = 1'b0;
    exp3("dual_same", 32'h10, 32'h04, 1'b1);
    tick(1);
    exp3("dual_same_after", 32'h10, 32'h04, 1'b0);

    // Asynchronous reset mid-operation
    irq[1] = 1'b1; irq[3] = 1'b1;
    tick(3);
    exp3("rst_setup", 32'h1A, 32'h04, 1'b0);
    do_claim(6'd1);
    exp3("rst_claim1", 32'h18, 32'h06, 1'b0);
    rst_n = 1'b0;
    #2;
    exp3("rst_async", 32'h0, 32'h0, 1'b0);
    tick(2);
    exp3("rst_held", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick(2);
    exp3("rst_rel_edge2", 32'h0, 32'h0, 1'b0);
    tick(1);
    exp3("rst_rel_edge3", 32'h1E, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
